// File: rtl/mem_to_fifo.sv
// mem_to_fifo: replays stored records [dflow_addr_low, dflow_mem_high) from memory into the TX FIFO.
// Build option LOOP_REPLAY_EN: continuous replay with a pass_cnt output instead of replay_done.
module mem_to_fifo #(
  parameter int FIFO_DATA_WIDTH = 144,
  parameter int MEM_ADDR_WIDTH  = 19,
  parameter int MEM_DATA_WIDTH  = 144,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sw_rst,
  input  logic                       cal_done,
  input  logic                       start_replay,
  input  logic [MEM_ADDR_WIDTH-1:0]  dflow_addr_low,
  input  logic [MEM_ADDR_WIDTH-1:0]  dflow_mem_high,
  output logic                       app_rd_cmd,
  output logic [MEM_ADDR_WIDTH-1:0]  app_rd_addr,
  input  logic                       app_rd_valid,
  input  logic [MEM_DATA_WIDTH-1:0]  app_rd_data,
  output logic                       fifo_wr_en,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_data,
  input  logic                       fifo_prog_full,
  input  logic                       fifo_full,
  output logic                       replay_done,
  output logic                       overflow_err
`ifdef LOOP_REPLAY_EN
  ,
  output logic [31:0]                pass_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0]      CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0]      CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE = MEM_ADDR_WIDTH'(1);

  state_t                      state_r, state_s;
  logic [MEM_ADDR_WIDTH-1:0]   rd_ptr_r, rd_ptr_s;
  logic [CNT_WIDTH-1:0]        outstanding_r;
  logic                        abort_r, abort_s;
  logic                        issue_s;
  logic                        wrap_s;
  logic                        any_rst_s;
  logic                        ret_s;

  assign any_rst_s = rst | sw_rst;
  // A return with nothing counted belongs to a read abandoned by reset; it must not underflow.
  assign ret_s     = app_rd_valid & (outstanding_r != CNT_ZERO);

  // Next-state, read pointer and issue decision.
  always_comb begin
    state_s  = state_r;
    rd_ptr_s = rd_ptr_r;
    abort_s  = abort_r;
    issue_s  = 1'b0;
    wrap_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        rd_ptr_s = dflow_addr_low;
        abort_s  = 1'b0;
        if (start_replay && cal_done) begin
          if (dflow_addr_low == dflow_mem_high) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (!start_replay) begin
          state_s = ST_DRAIN;
          abort_s = 1'b1;
        end else if (rd_ptr_r == dflow_mem_high) begin
`ifdef LOOP_REPLAY_EN
          rd_ptr_s = dflow_addr_low;
          wrap_s   = 1'b1;
          state_s  = ST_READ;
`else
          state_s  = ST_DRAIN;
          abort_s  = 1'b0;
`endif
        end else begin
          issue_s = cal_done && !fifo_prog_full && (outstanding_r < CNT_MAX);
          if (issue_s) begin
            rd_ptr_s = rd_ptr_r + ADDR_ONE;
          end else begin
            rd_ptr_s = rd_ptr_r;
          end
        end
      end
      ST_DRAIN: begin
        if (outstanding_r == CNT_ZERO) begin
          if (abort_r) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (!start_replay) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, pointer and outstanding-read bookkeeping.
  always_ff @(posedge clk) begin
    if (any_rst_s) begin
      state_r       <= ST_IDLE;
      rd_ptr_r      <= dflow_addr_low;
      abort_r       <= 1'b0;
      outstanding_r <= CNT_ZERO;
    end else begin
      state_r  <= state_s;
      rd_ptr_r <= rd_ptr_s;
      abort_r  <= abort_s;
      case ({issue_s, ret_s})
        2'b10:   outstanding_r <= outstanding_r + CNT_ONE;
        2'b01:   outstanding_r <= outstanding_r - CNT_ONE;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Registered command, data path and status outputs.
  always_ff @(posedge clk) begin
    if (any_rst_s) begin
      app_rd_cmd   <= 1'b0;
      app_rd_addr  <= {MEM_ADDR_WIDTH{1'b0}};
      fifo_wr_en   <= 1'b0;
      fifo_data    <= {FIFO_DATA_WIDTH{1'b0}};
      replay_done  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      app_rd_cmd <= issue_s;
      if (issue_s) begin
        app_rd_addr <= rd_ptr_r;
      end
      fifo_wr_en   <= app_rd_valid;
      fifo_data    <= FIFO_DATA_WIDTH'(app_rd_data);
      overflow_err <= overflow_err | (app_rd_valid & fifo_full);
`ifdef LOOP_REPLAY_EN
      replay_done  <= 1'b0;
`else
      replay_done  <= (state_s == ST_DONE);
`endif
    end
  end

`ifdef LOOP_REPLAY_EN
  // Completed-pass counter, stepped on each wrap back to the region start.
  always_ff @(posedge clk) begin
    if (any_rst_s) begin
      pass_cnt <= 32'd0;
    end else if (wrap_s) begin
      pass_cnt <= pass_cnt + 32'd1;
    end else begin
      pass_cnt <= pass_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_mem_to_fifo.sv
// Self-checking bench for mem_to_fifo: memory model with fixed read latency, address scoreboard,
// per-cycle data-path/overflow/backpressure checks and directed replay scenarios.
module tb_mem_to_fifo;
  localparam int MAW = 19;
  localparam int MDW = 144;
  typedef logic [MDW-1:0] w_t;
  typedef struct {
    int             due;
    logic [MAW-1:0] addr;
  } rd_t;

  logic           clk = 1'b0;
  logic           rst, sw_rst, cal_done, start_replay;
  logic [MAW-1:0] dflow_addr_low, dflow_mem_high;
  logic           app_rd_cmd;
  logic [MAW-1:0] app_rd_addr;
  logic           app_rd_valid = 1'b0;
  logic [MDW-1:0] app_rd_data = '0;
  logic           fifo_wr_en;
  logic [MDW-1:0] fifo_data;
  logic           fifo_prog_full, fifo_full;
  logic           replay_done, overflow_err;
`ifdef LOOP_REPLAY_EN
  logic [31:0]    pass_cnt;
`endif

  always #5 clk = ~clk;

  mem_to_fifo dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .cal_done(cal_done), .start_replay(start_replay),
    .dflow_addr_low(dflow_addr_low), .dflow_mem_high(dflow_mem_high),
    .app_rd_cmd(app_rd_cmd), .app_rd_addr(app_rd_addr),
    .app_rd_valid(app_rd_valid), .app_rd_data(app_rd_data),
    .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .fifo_prog_full(fifo_prog_full), .fifo_full(fifo_full),
    .replay_done(replay_done), .overflow_err(overflow_err)
`ifdef LOOP_REPLAY_EN
    , .pass_cnt(pass_cnt)
`endif
  );

  rd_t            mem_q[$];
  logic [MAW-1:0] exp_q[$];
  logic [MDW-1:0] push_log[$];
  int  nerr = 0, nchk = 0, ncmd = 0, npush = 0, cyc = 0, out_m = 0;
  int  lat = 2;
  bit  withhold = 1'b0, prev_valid = 1'b0, ovf_m = 1'b0;
  logic [MDW-1:0] prev_data = '0;

  function automatic logic [MDW-1:0] mdata(input logic [MAW-1:0] a);
    return {a ^ 19'h5A5A5, 106'h0, ~a};
  endfunction

  task automatic chk(input string name, input w_t act, input w_t exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor + memory model: sample just after each rising edge, then drive next return.
  initial begin
    rd_t r;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      chk("wr_en", w_t'(fifo_wr_en), w_t'(prev_valid && !rst && !sw_rst));
      if (fifo_wr_en) begin
        chk("wr_data", fifo_data, prev_data);
        npush++;
        push_log.push_back(fifo_data);
      end
      if (rst || sw_rst) ovf_m = 1'b0;
      else if (prev_valid && fifo_full) ovf_m = 1'b1;
      chk("overflow", w_t'(overflow_err), w_t'(ovf_m));
      if (rst || sw_rst) out_m = 0;
      if (app_rd_cmd) begin
        ncmd++;
        chk("cmd_gate", w_t'({cal_done, fifo_prog_full}), w_t'(2'b10));
        chk("cmd_cap", w_t'(out_m < 8), w_t'(1'b1));
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL cmd_unexpected: addr %h issued with none expected", app_rd_addr);
        end else begin
          chk("cmd_addr", w_t'(app_rd_addr), w_t'(exp_q.pop_front()));
        end
        mem_q.push_back('{due: cyc + lat, addr: app_rd_addr});
        out_m++;
      end
      if (!withhold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        r = mem_q.pop_front();
        app_rd_valid = 1'b1;
        app_rd_data  = mdata(r.addr);
        out_m--;
      end else begin
        app_rd_valid = 1'b0;
      end
      prev_valid = app_rd_valid;
      prev_data  = app_rd_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setup(input logic [MAW-1:0] lo, input logic [MAW-1:0] hi, input int nexp);
    logic [MAW-1:0] a;
    dflow_addr_low = lo;
    dflow_mem_high = hi;
    npush = 0;
    push_log.delete();
    exp_q.delete();
    a = lo;
    for (int i = 0; i < nexp; i++) begin
      exp_q.push_back(a);
      a = a + 19'd1;
      if (a == hi) a = lo;
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int t = 0;
    while (!replay_done && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, w_t'(replay_done), w_t'(1'b1));
  endtask

  task automatic wait_cmds(input int base, input int n, input int budget);
    int t = 0;
    while ((ncmd - base) < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_wait", w_t'(ncmd - base >= n), w_t'(1'b1));
  endtask

  task automatic stop_replay();
    start_replay = 1'b0;
    cycles(3);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd"}, w_t'(app_rd_cmd), w_t'(1'b0));
    chk({tag, "_addr"}, w_t'(app_rd_addr), w_t'(19'h0));
    chk({tag, "_wr_en"}, w_t'(fifo_wr_en), w_t'(1'b0));
    chk({tag, "_data"}, fifo_data, w_t'(0));
    chk({tag, "_done"}, w_t'(replay_done), w_t'(1'b0));
    chk({tag, "_ovf"}, w_t'(overflow_err), w_t'(1'b0));
  endtask

  initial begin
    int base, c0;
    rst = 1'b1; sw_rst = 1'b0; cal_done = 1'b1; start_replay = 1'b0;
    fifo_prog_full = 1'b0; fifo_full = 1'b0;
    dflow_addr_low = 19'h10; dflow_mem_high = 19'h14;
    cycles(3);
    chk_all_zero("reset");
    rst = 1'b0;
    cycles(2);

`ifdef LOOP_REPLAY_EN
    // Continuous replay of 0..3: three passes, two wraps by the twelfth read.
    setup(19'h0, 19'h4, 12);
    base = ncmd;
    start_replay = 1'b1;
    wait_cmds(base, 12, 200);
    start_replay = 1'b0;
    cycles(20);
    chk("t6_cmds", w_t'(ncmd - base), w_t'(12));
    chk("t6_pass_cnt", w_t'(pass_cnt), w_t'(32'd2));
    chk("t6_pushes", w_t'(npush), w_t'(12));
    chk("t6_done", w_t'(replay_done), w_t'(1'b0));
`else
    // Test 1: basic pass 0x10..0x13.
    setup(19'h10, 19'h14, 4);
    base = ncmd;
    start_replay = 1'b1;
    wait_done(100, "t1_done");
    chk("t1_cmds", w_t'(ncmd - base), w_t'(4));
    chk("t1_pushes", w_t'(npush), w_t'(4));
    chk("t1_data0", push_log[0], {19'h5A5B5, 106'h0, 19'h7FFEF});
    for (int i = 1; i < 4; i++) chk("t1_data", push_log[i], mdata(19'h10 + 19'(i)));
    chk("t1_exp_left", w_t'(exp_q.size()), w_t'(0));
    stop_replay();

    // Test 2: prog_full stall for 50 cycles, then a cal_done pause, then completion.
    setup(19'h200, 19'h240, 64);
    base = ncmd;
    start_replay = 1'b1;
    wait_cmds(base, 10, 100);
    fifo_prog_full = 1'b1;
    c0 = ncmd;
    cycles(50);
    chk("t2_stall_pf", w_t'(ncmd - c0), w_t'(0));
    fifo_prog_full = 1'b0;
    cycles(5);
    cal_done = 1'b0;
    c0 = ncmd;
    cycles(10);
    chk("t2_stall_cal", w_t'(ncmd - c0), w_t'(0));
    cal_done = 1'b1;
    wait_done(500, "t2_done");
    chk("t2_pushes", w_t'(npush), w_t'(64));
    chk("t2_exp_left", w_t'(exp_q.size()), w_t'(0));
    chk("t2_ovf", w_t'(overflow_err), w_t'(1'b0));
    stop_replay();

    // Test 3: returns withheld, exactly MAX_OUTSTANDING commands go out.
    setup(19'h400, 19'h420, 32);
    base = ncmd;
    withhold = 1'b1;
    start_replay = 1'b1;
    cycles(30);
    chk("t3_cap_cmds", w_t'(ncmd - base), w_t'(8));
    chk("t3_no_push", w_t'(npush), w_t'(0));
    withhold = 1'b0;
    wait_done(400, "t3_done");
    chk("t3_pushes", w_t'(npush), w_t'(32));
    stop_replay();

    // Test 4: empty region finishes at once.
    setup(19'h20, 19'h20, 0);
    base = ncmd;
    start_replay = 1'b1;
    @(negedge clk);
    chk("t4_done", w_t'(replay_done), w_t'(1'b1));
    chk("t4_no_cmd", w_t'(ncmd - base), w_t'(0));
    start_replay = 1'b0;
    @(negedge clk);
    chk("t4_idle", w_t'(replay_done), w_t'(1'b0));
    cycles(2);

    // Test 5: abort after 3 of 100 reads; in-flight reads still pushed.
    setup(19'h100, 19'h164, 3);
    base = ncmd;
    start_replay = 1'b1;
    wait_cmds(base, 3, 50);
    start_replay = 1'b0;
    cycles(20);
    chk("t5_cmds", w_t'(ncmd - base), w_t'(3));
    chk("t5_pushes", w_t'(npush), w_t'(3));
    chk("t5_done", w_t'(replay_done), w_t'(1'b0));

    // Test 7: returns while FIFO full raise sticky overflow; sw_rst clears everything.
    setup(19'h300, 19'h302, 2);
    fifo_full = 1'b1;
    start_replay = 1'b1;
    wait_done(100, "t7_done");
    chk("t7_ovf", w_t'(overflow_err), w_t'(1'b1));
    chk("t7_pushes", w_t'(npush), w_t'(2));
    fifo_full = 1'b0;
    stop_replay();
    chk("t7_ovf_sticky", w_t'(overflow_err), w_t'(1'b1));
    sw_rst = 1'b1;
    @(negedge clk);
    chk_all_zero("swrst");
    sw_rst = 1'b0;
    cycles(3);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
